// File: rtl/alu_sync_arbiter.sv
// -----------------------------------------------------------------------------
// alu_sync_arbiter
//
// Shares the ALU's multi-cycle (synchronous) path between two requesters.
// The arbiter picks a requester round-robin and latches its operation. It then
// sequences the ALU trigger_sync / busy / result_ready handshake and returns a
// one-cycle response pulse to the owner. Opcodes below MUL (0..6) never reach
// the ALU; they are answered with an error response.
//
// Optional feature macro: ALU_ARB_TIMEOUT_EN
//   When this macro is defined, a WAIT that lasts TIMEOUT_CYCLES cycles is
//   aborted, and the owner receives an error response.
//
// Ports:
//   clock, reset_n                   clock (rising edge), async active-low reset
//   reqN_valid/op/in1/in2  (N=0,1)   request, held until reqN_ready
//   reqN_ready                       combinational accept strobe
//   respN_valid/data/err             one-cycle response to the owner
//   alu_operation/in1/in2            latched operation driven to the ALU
//   alu_trigger_sync                 one-cycle start pulse to the ALU
//   alu_busy, alu_result_ready,
//   alu_out_sync                     status and result from the ALU
// -----------------------------------------------------------------------------
module alu_sync_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req0_valid,
    input  logic [3:0]  req0_op,
    input  logic [31:0] req0_in1,
    input  logic [31:0] req0_in2,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [3:0]  req1_op,
    input  logic [31:0] req1_in1,
    input  logic [31:0] req1_in2,
    output logic        req1_ready,
    output logic        resp0_valid,
    output logic [31:0] resp0_data,
    output logic        resp0_err,
    output logic        resp1_valid,
    output logic [31:0] resp1_data,
    output logic        resp1_err,
    output logic [3:0]  alu_operation,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic        alu_trigger_sync,
    input  logic        alu_busy,
    input  logic        alu_result_ready,
    input  logic [31:0] alu_out_sync
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } state_t;

    // Multiply/divide family (MUL..REMU) occupies opcodes 7..15
    function automatic logic is_sync_op(input logic [3:0] op);
        return (op >= 4'd7);
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_last;      // owner of the most recently accepted request
    logic        r_owner;     // owner of the operation in flight
    logic        r_err;
    logic [31:0] r_data;
    logic [3:0]  r_op;
    logic [31:0] r_in1;
    logic [31:0] r_in2;

    logic        w_grant0;
    logic        w_grant1;
    logic        w_acc0;
    logic        w_acc1;
    logic [3:0]  w_acc_op;
    logic        w_trigger;
    logic        w_complete;
    logic        w_timeout;

    // Round-robin grant: on a tie, the requester not served last wins
    always_comb begin
        w_grant0 = req0_valid && (!req1_valid || r_last);
        w_grant1 = req1_valid && (!req0_valid || !r_last);
    end

    assign w_acc0     = (r_state == ST_IDLE) && w_grant0;
    assign w_acc1     = (r_state == ST_IDLE) && w_grant1;
    assign w_acc_op   = w_acc1 ? req1_op : req0_op;
    // The ALU updates both flags on the trigger edge, so the first WAIT cycle is valid
    assign w_complete = alu_result_ready && !alu_busy;

`ifdef ALU_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] r_wait_cnt;

    // WAIT cycle counter: cleared while issuing, counts every WAIT cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt <= 8'd0;
        end else if (r_state == ST_ISSUE) begin
            r_wait_cnt <= 8'd0;
        end else if (r_state == ST_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    // The last allowed WAIT cycle is the one that sees count TIMEOUT_CYCLES-1
    assign w_timeout = (r_state == ST_WAIT) && (r_wait_cnt == TO_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    // Next-state and trigger decode
    always_comb begin
        w_state_nxt = r_state;
        w_trigger   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_acc0 || w_acc1) begin
                    w_state_nxt = is_sync_op(w_acc_op) ? ST_ISSUE : ST_RESPOND;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // An ALU still busy from an aborted operation must drain first
                if (!alu_busy) begin
                    w_trigger   = 1'b1;
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (w_complete || w_timeout) begin
                    w_state_nxt = ST_RESPOND;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_RESPOND: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request latch, round-robin history and response data/error capture
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_last  <= 1'b1;
            r_owner <= 1'b0;
            r_op    <= 4'd0;
            r_in1   <= 32'd0;
            r_in2   <= 32'd0;
            r_data  <= 32'd0;
            r_err   <= 1'b0;
        end else if (w_acc0 || w_acc1) begin
            r_last  <= w_acc1;
            r_owner <= w_acc1;
            r_op    <= w_acc_op;
            r_in1   <= w_acc1 ? req1_in1 : req0_in1;
            r_in2   <= w_acc1 ? req1_in2 : req0_in2;
            r_data  <= 32'd0;
            // Illegal opcodes respond next cycle with err set and zero data
            r_err   <= !is_sync_op(w_acc_op);
        end else if ((r_state == ST_WAIT) && w_complete) begin
            r_data <= alu_out_sync;
            r_err  <= 1'b0;
        end else if (w_timeout) begin
            r_data <= 32'd0;
            r_err  <= 1'b1;
        end
    end

    assign req0_ready       = w_acc0;
    assign req1_ready       = w_acc1;
    assign alu_trigger_sync = w_trigger;
    // Operands come straight from the latch, so they hold through ISSUE/WAIT and IDLE
    assign alu_operation    = r_op;
    assign alu_in1          = r_in1;
    assign alu_in2          = r_in2;

    // Responses are decoded from registered state; the non-owner side stays 0
    assign resp0_valid = (r_state == ST_RESPOND) && !r_owner;
    assign resp1_valid = (r_state == ST_RESPOND) && r_owner;
    assign resp0_data  = resp0_valid ? r_data : 32'd0;
    assign resp1_data  = resp1_valid ? r_data : 32'd0;
    assign resp0_err   = resp0_valid && r_err;
    assign resp1_err   = resp1_valid && r_err;

endmodule
